mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
- REQ-001 Parameter: LOCK_ENABLE, default 1, meaning lock inputs are honored; 0 means lock inputs are ignored.
- REQ-002 Port: clk, in, 1, the block's single clock; all state updates on the posedge.
- REQ-003 Port: reset, in, 1, synchronous, active-high reset.
- REQ-004 Port: req0 / req1, in, 1 each, request from requester 0 (core) / 1 (DMA or debug).
- REQ-005 Port: op0 / op1, in, 2 each, memory operation code (MEM_NOP / MEM_READ / MEM_WRITE).
- REQ-006 Port: addr0 / addr1, in, WORD_SIZE each, data-memory address.
- REQ-007 Port: wdata0 / wdata1, in, WORD_SIZE each, write data.
- REQ-008 Port: lock0 / lock1, in, 1 each, hold ownership after the current access.
- REQ-009 Port: ack0 / ack1, out, 1 each, one-cycle completion pulse.
- REQ-010 Port: rdata0 / rdata1, out, WORD_SIZE each, registered read result, valid while the matching ack is high.
- REQ-011 Port: mem_op, out, 2, operation to the data memory; registered.
- REQ-012 Port: mem_addr, out, WORD_SIZE, address to the data memory; registered.
- REQ-013 Port: mem_wdata, out, WORD_SIZE, write data to the data memory; registered.
- REQ-014 Port: mem_rdata, in, WORD_SIZE, combinational read data returned by the data memory.
- REQ-015 Port: busy, out, 1, high in any state other than ARB_IDLE.
- REQ-016 Port: owner, out, 1, index of the last granted requester.

Function
- REQ-017 Requester obligations: hold op/addr/wdata stable from req assertion until its ack; a req still high on the cycle after ack is a new request.
- REQ-018 State ARB_IDLE:
  - on any req, select a winner, register its op/addr/wdata onto the mem_* outputs, go to ARB_ACCESS;
  - otherwise mem_op = MEM_NOP.
- REQ-019 State ARB_ACCESS: lasts exactly one cycle; memory is driven; if mem_op = MEM_READ, capture mem_rdata into the winner's rdata register; go to ARB_RESP.
- REQ-020 State ARB_RESP: lasts exactly one cycle.
  - mem_op = MEM_NOP.
  - Winner's ack = 1; the other ack = 0.
  - Go to ARB_IDLE.
- REQ-021 Latency: req sampled at edge k -> memory access in cycle k+1 -> ack in cycle k+2; throughput is one access per 3 cycles.
- REQ-022 Selection: round-robin. On simultaneous req0 and req1, grant the requester that is not owner; a single requester always wins.
- REQ-023 owner updates to the winner on the ARB_IDLE->ARB_ACCESS edge.
- REQ-024 Lock: if LOCK_ENABLE=1 and the winner's lock is high during ARB_RESP, the next ARB_IDLE considers only that requester, until a completed access with lock low.
- REQ-025 Locked requester with req low in ARB_IDLE: the arbiter waits and grants nobody.
- REQ-026 A granted op of MEM_NOP or the reserved code: issue no memory access (mem_op = MEM_NOP), still ack with rdata = 0.
- REQ-027 A write leaves the winner's rdata unchanged; the non-winner's rdata is never modified.
- REQ-028 ack0 and ack1 are never high in the same cycle.

Reset
- REQ-029 Reset forces the following, regardless of state, aborting any in-flight access without ack:
  - state = ARB_IDLE;
  - mem_op = MEM_NOP;
  - mem_addr, mem_wdata, rdata0, rdata1 = 0;
  - ack0, ack1, busy = 0;
  - owner = 1, so requester 0 wins the first tie;
  - lock cleared.
- REQ-030 Reset takes priority over every other transition in the same cycle.

Structure
- REQ-031 arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_RESP} and MEM_NOP belong in package instruction_set, alongside MEM_READ, MEM_WRITE and WORD_SIZE.
- REQ-032 One sub-module, rr_pick2: combinational 2-way round-robin picker with inputs req[1:0], last, lock_valid, lock_idx; outputs grant_valid and grant_idx.

Verification
- REQ-033 Single read: after reset, req0 with MEM_READ, addr 0x10; memory returns 0x5A -> mem_op = READ, mem_addr = 0x10 in cycle k+1; ack0 = 1 and rdata0 = 0x5A in cycle k+2; ack1 never asserted.
- REQ-034 Tie and alternation: req0 and req1 both held continuously, with writes to addresses 0x01 and 0x02 -> grant order 0,1,0,1; acks 3 cycles apart; mem_wdata matches each requester's wdata.
- REQ-035 Lock:
  - Stimulus: req1 holds lock1 = 1 for 3 accesses while req0 is continuously pending.
  - Response: three consecutive grants to requester 1, then requester 0 on the next grant.
- REQ-036 Reset mid-access: assert reset during ARB_ACCESS -> next cycle state = ARB_IDLE, mem_op = NOP, no ack, rdata0 = rdata1 = 0, busy = 0.
- REQ-037 NOP request: req1 with op MEM_NOP -> mem_op stays NOP throughout; ack1 with rdata1 = 0 in cycle k+2.
- REQ-038 Write data: req0 write of 0xC3 to address 0x20 -> mem_op = WRITE, mem_addr = 0x20, mem_wdata = 0xC3 for exactly one cycle; rdata0 unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port definitions: operation codes, word width and the arbiter state type.
package instruction_set;

    localparam int WORD_SIZE = 16;

    // Code 2'b11 is reserved and is treated like MEM_NOP by the arbiter.
    localparam logic [1:0] MEM_NOP   = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] MEM_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    function automatic logic is_mem_access(input logic [1:0] op);
        return (op == MEM_READ) || (op == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker with an optional ownership lock.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_valid,
    input  logic       lock_idx,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last;
        if (lock_valid) begin
            // A locked owner is the only candidate; if it is idle nobody wins.
            grant_valid = req[lock_idx];
            grant_idx   = lock_idx;
        end else begin
            case (req)
                2'b01:   begin grant_valid = 1'b1; grant_idx = 1'b0;  end
                2'b10:   begin grant_valid = 1'b1; grant_idx = 1'b1;  end
                2'b11:   begin grant_valid = 1'b1; grant_idx = ~last; end
                default: begin grant_valid = 1'b0; grant_idx = last;  end
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester data-memory port arbiter: IDLE -> ACCESS -> RESP, round-robin with lock.
module mem_port_arbiter
    import instruction_set::*;
#(
    parameter int LOCK_ENABLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [1:0]           op0,
    input  logic [1:0]           op1,
    input  logic [WORD_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata0,
    input  logic [WORD_SIZE-1:0] wdata1,
    input  logic                 lock0,
    input  logic                 lock1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [WORD_SIZE-1:0] rdata0,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic [1:0]           mem_op,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic                 owner
);

    arb_state_t           state_q, state_d;
    logic                 owner_q, owner_d;
    logic [1:0]           op_q, op_d;
    logic [1:0]           mem_op_q, mem_op_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 lock_valid_q, lock_valid_d;
    logic [WORD_SIZE-1:0] rdata_q [2];
    logic [WORD_SIZE-1:0] rdata_d [2];

    logic [1:0]           req_vec;
    logic [1:0]           lock_vec;
    logic [1:0]           ack_vec;
    logic                 grant_valid;
    logic                 grant_idx;
    logic [1:0]           op_sel;
    logic [WORD_SIZE-1:0] addr_sel;
    logic [WORD_SIZE-1:0] wdata_sel;

    assign req_vec  = {req1, req0};
    assign lock_vec = {lock1, lock0};

    // The lock always belongs to the current owner, so owner doubles as the lock index.
    rr_pick2 u_pick (
        .req         (req_vec),
        .last        (owner_q),
        .lock_valid  (lock_valid_q),
        .lock_idx    (owner_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign op_sel    = grant_idx ? op1    : op0;
    assign addr_sel  = grant_idx ? addr1  : addr0;
    assign wdata_sel = grant_idx ? wdata1 : wdata0;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_d         = op_q;
        mem_op_d     = mem_op_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        lock_valid_d = lock_valid_q;
        case (state_q)
            ARB_IDLE: begin
                mem_op_d = MEM_NOP;
                if (grant_valid) begin
                    state_d     = ARB_ACCESS;
                    owner_d     = grant_idx;
                    op_d        = op_sel;
                    mem_op_d    = is_mem_access(op_sel) ? op_sel : MEM_NOP;
                    mem_addr_d  = addr_sel;
                    mem_wdata_d = wdata_sel;
                end
            end
            ARB_ACCESS: begin
                // The memory sees the request for exactly one cycle.
                state_d     = ARB_RESP;
                mem_op_d    = MEM_NOP;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
            end
            ARB_RESP: begin
                state_d      = ARB_IDLE;
                lock_valid_d = (LOCK_ENABLE != 0) && lock_vec[owner_q];
            end
            default: begin
                state_d  = ARB_IDLE;
                mem_op_d = MEM_NOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b1;
            op_q         <= MEM_NOP;
            mem_op_q     <= MEM_NOP;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            lock_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            mem_op_q     <= mem_op_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            lock_valid_q <= lock_valid_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // Reads capture memory data, writes keep the old value, NOP/reserved clear it.
            always_comb begin
                rdata_d[gi] = rdata_q[gi];
                if ((state_q == ARB_ACCESS) && (owner_q == 1'(gi))) begin
                    if (op_q == MEM_READ) begin
                        rdata_d[gi] = mem_rdata;
                    end else if (op_q != MEM_WRITE) begin
                        rdata_d[gi] = '0;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q[gi] <= '0;
                end else begin
                    rdata_q[gi] <= rdata_d[gi];
                end
            end

            assign ack_vec[gi] = (state_q == ARB_RESP) && (owner_q == 1'(gi));
        end
    endgenerate

    assign ack0      = ack_vec[0];
    assign ack1      = ack_vec[1];
    assign rdata0    = rdata_q[0];
    assign rdata1    = rdata_q[1];
    assign mem_op    = mem_op_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ARB_IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected accesses and acks queued at drive time.
module tb_mem_port_arbiter;
    import instruction_set::*;

    typedef struct packed {
        logic                 idx;
        logic [WORD_SIZE-1:0] rdata;
    } ack_exp_t;

    typedef struct packed {
        logic [1:0]           op;
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] wdata;
    } acc_exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req0, req1, lock0, lock1;
    logic [1:0]           op0, op1;
    logic [WORD_SIZE-1:0] addr0, addr1, wdata0, wdata1;
    logic                 ack0, ack1, busy, owner;
    logic [WORD_SIZE-1:0] rdata0, rdata1;
    logic [1:0]           mem_op;
    logic [WORD_SIZE-1:0] mem_addr, mem_wdata, mem_rdata;

    ack_exp_t ack_q[$];
    acc_exp_t acc_q[$];
    int       checks = 0;
    int       passed = 0;
    int       cyc = 0;
    logic     got_ack;
    logic     last_ack_idx;

    mem_port_arbiter #(.LOCK_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory model: read data is a fixed function of the address (0x10 -> 0x5A).
    assign mem_rdata = mem_addr ^ 16'h004A;

    task automatic tick();
        ack_exp_t ae;
        acc_exp_t ce;
        logic [WORD_SIZE-1:0] rd;
        @(posedge clk);
        #1;
        cyc++;
        got_ack = 1'b0;
        if (!reset) begin
            checks++;
            if (ack0 && ack1) $display("FAIL dual_ack: ack0=%b ack1=%b, required not both", ack0, ack1);
            else passed++;
            if (ack0 || ack1) begin
                got_ack = 1'b1;
                last_ack_idx = ack1;
                checks++;
                rd = ack1 ? rdata1 : rdata0;
                if (ack_q.size() == 0) begin
                    $display("FAIL unexpected_ack: cycle %0d idx=%0d rdata=%h, required no ack", cyc, ack1, rd);
                end else begin
                    ae = ack_q.pop_front();
                    if (ack1 !== ae.idx || rd !== ae.rdata)
                        $display("FAIL ack: cycle %0d idx=%0d rdata=%h, required idx=%0d rdata=%h",
                                 cyc, ack1, rd, ae.idx, ae.rdata);
                    else passed++;
                end
            end
            if (mem_op !== MEM_NOP) begin
                checks++;
                if (acc_q.size() == 0) begin
                    $display("FAIL unexpected_access: cycle %0d op=%0d addr=%h, required MEM_NOP", cyc, mem_op, mem_addr);
                end else begin
                    ce = acc_q.pop_front();
                    if (mem_op !== ce.op || mem_addr !== ce.addr || mem_wdata !== ce.wdata)
                        $display("FAIL access: cycle %0d op=%0d addr=%h wdata=%h, required op=%0d addr=%h wdata=%h",
                                 cyc, mem_op, mem_addr, mem_wdata, ce.op, ce.addr, ce.wdata);
                    else passed++;
                end
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_txn(input logic idx, input logic [1:0] op, input logic [WORD_SIZE-1:0] addr,
                          input logic [WORD_SIZE-1:0] wdata, input logic [WORD_SIZE-1:0] exp_rdata,
                          input logic exp_access);
        int n;
        if (idx) begin req1 = 1'b1; op1 = op; addr1 = addr; wdata1 = wdata; end
        else     begin req0 = 1'b1; op0 = op; addr0 = addr; wdata0 = wdata; end
        if (exp_access) acc_q.push_back('{op: op, addr: addr, wdata: wdata});
        ack_q.push_back('{idx: idx, rdata: exp_rdata});
        n = 0;
        got_ack = 1'b0;
        while (!got_ack && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!got_ack || n != 2)
            $display("FAIL latency: idx=%0d op=%0d ack after %0d cycles (seen=%b), required 2", idx, op, n, got_ack);
        else passed++;
        if (idx) req1 = 1'b0; else req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({mem_op, mem_addr, mem_wdata} !== {MEM_NOP, 32'h0})
            $display("FAIL reset_mem: op=%0d addr=%h wdata=%h, required 0/0/0", mem_op, mem_addr, mem_wdata);
        else passed++;
        checks++;
        if ({rdata0, rdata1} !== 32'h0) $display("FAIL reset_rdata: %h %h, required 0 0", rdata0, rdata1);
        else passed++;
        checks++;
        if ({ack0, ack1, busy} !== 3'b000) $display("FAIL reset_flags: ack0/ack1/busy=%b, required 000", {ack0, ack1, busy});
        else passed++;
        checks++;
        if (owner !== 1'b1) $display("FAIL reset_owner: %b, required 1", owner);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_txn(1'b0, MEM_READ, 16'h0010, 16'h0, 16'h005A, 1'b1);
        checks++;
        if (owner !== 1'b0 || busy !== 1'b0) $display("FAIL read_after: owner=%b busy=%b, required 0 0", owner, busy);
        else passed++;
    endtask

    task automatic test_tie();
        int acks, prev, n;
        apply_reset();
        req0 = 1'b1; op0 = MEM_WRITE; addr0 = 16'h0001; wdata0 = 16'h1111;
        req1 = 1'b1; op1 = MEM_WRITE; addr1 = 16'h0002; wdata1 = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            acc_q.push_back('{op: MEM_WRITE, addr: 16'h0001, wdata: 16'h1111});
            acc_q.push_back('{op: MEM_WRITE, addr: 16'h0002, wdata: 16'h2222});
            ack_q.push_back('{idx: 1'b0, rdata: 16'h0});
            ack_q.push_back('{idx: 1'b1, rdata: 16'h0});
        end
        acks = 0; prev = 0; n = 0;
        while (acks < 4 && n < 20) begin
            tick();
            n++;
            if (got_ack) begin
                acks++;
                if (acks > 1) begin
                    checks++;
                    if (cyc - prev != 3) $display("FAIL tie_spacing: %0d cycles, required 3", cyc - prev);
                    else passed++;
                end
                prev = cyc;
                if (acks == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        checks++;
        if (acks != 4) $display("FAIL tie_count: %0d acks, required 4", acks);
        else passed++;
        tick();
    endtask

    task automatic test_lock();
        int acc1, n;
        logic done;
        apply_reset();
        req1 = 1'b1; op1 = MEM_READ; addr1 = 16'h0030; wdata1 = 16'h0; lock1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc_q.push_back('{op: MEM_READ, addr: 16'h0030, wdata: 16'h0});
            ack_q.push_back('{idx: 1'b1, rdata: 16'h007A});
        end
        acc_q.push_back('{op: MEM_WRITE, addr: 16'h0040, wdata: 16'h4444});
        ack_q.push_back('{idx: 1'b0, rdata: 16'h0});
        acc1 = 0; n = 0; done = 1'b0;
        while (!done && n < 30) begin
            tick();
            n++;
            if (n == 1) begin req0 = 1'b1; op0 = MEM_WRITE; addr0 = 16'h0040; wdata0 = 16'h4444; end
            if (mem_op !== MEM_NOP && mem_addr === 16'h0030) begin
                acc1++;
                if (acc1 == 3) lock1 = 1'b0;
            end
            if (got_ack && last_ack_idx && acc1 == 3) req1 = 1'b0;
            if (got_ack && !last_ack_idx) begin req0 = 1'b0; done = 1'b1; end
        end
        checks++;
        if (!done || acc1 != 3) $display("FAIL lock_seq: done=%b grants1=%0d, required 1 and 3", done, acc1);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; op0 = MEM_READ; addr0 = 16'h0010; wdata0 = 16'h0;
        acc_q.push_back('{op: MEM_READ, addr: 16'h0010, wdata: 16'h0});
        tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL mid_busy: %b, required 1", busy);
        else passed++;
        reset = 1'b1;
        req0 = 1'b0;
        tick();
        checks++;
        if ({mem_op, ack0, ack1, busy} !== {MEM_NOP, 3'b000})
            $display("FAIL mid_reset_ctl: op=%0d ack0=%b ack1=%b busy=%b, required 0 0 0 0", mem_op, ack0, ack1, busy);
        else passed++;
        checks++;
        if ({rdata0, rdata1} !== 32'h0) $display("FAIL mid_reset_rdata: %h %h, required 0 0", rdata0, rdata1);
        else passed++;
        reset = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_nop();
        do_txn(1'b1, MEM_READ, 16'h0030, 16'h0, 16'h007A, 1'b1);
        do_txn(1'b1, MEM_NOP, 16'h0055, 16'h0099, 16'h0, 1'b0);
        do_txn(1'b0, MEM_READ, 16'h0010, 16'h0, 16'h005A, 1'b1);
        do_txn(1'b0, MEM_RSVD, 16'h0066, 16'h0, 16'h0, 1'b0);
        checks++;
        if (rdata1 !== 16'h0) $display("FAIL nop_rdata1: %h, required 0", rdata1);
        else passed++;
    endtask

    task automatic test_write();
        do_txn(1'b0, MEM_READ, 16'h0010, 16'h0, 16'h005A, 1'b1);
        do_txn(1'b0, MEM_WRITE, 16'h0020, 16'h00C3, 16'h005A, 1'b1);
        checks++;
        if (rdata0 !== 16'h005A || mem_op !== MEM_NOP)
            $display("FAIL write_after: rdata0=%h op=%0d, required 005a 0", rdata0, mem_op);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        op0 = MEM_NOP; op1 = MEM_NOP;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_single_read();
        test_tie();
        test_lock();
        test_reset_mid();
        test_nop();
        test_write();
        checks++;
        if (ack_q.size() != 0 || acc_q.size() != 0)
            $display("FAIL leftover: %0d acks and %0d accesses outstanding, required 0 0", ack_q.size(), acc_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
